// File: rtl/spi_ram_ctrl_p.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl_p
//
// Single-port RAM slave that sits behind the SPI slave shift logic. Each
// received frame carries a 2-bit command and a DATA_W-bit payload:
//   00 write address   -> load wr_ptr (range checked)
//   01 write data      -> mem[wr_ptr] <= payload (needs a valid wr_ptr)
//   10 read address    -> load rd_ptr (range checked)
//   11 read data       -> dout <= mem[rd_ptr], tx_valid pulse (needs rd_ptr)
// Rejected frames produce a one-cycle err pulse and change no state.
//
// Optional feature (macro SPI_RAM_AUTOINC_EN): after each accepted data frame
// the matching pointer advances by one, wrapping at MEM_DEPTH, so a burst
// needs only one address frame.
//
// Parameters:
//   DATA_W     payload / memory word width (din is DATA_W+2 bits)
//   MEM_DEPTH  number of memory words, 2..2**DATA_W
//   ADDR_SIZE  pointer width, 2**ADDR_SIZE >= MEM_DEPTH, ADDR_SIZE <= DATA_W
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   rx_valid  din holds a valid frame this cycle
//   din       {cmd[1:0], payload[DATA_W-1:0]}
//   dout      registered read data, held until the next successful read
//   tx_valid  one-cycle pulse, dout carries new read data
//   err       one-cycle pulse, frame rejected
// -----------------------------------------------------------------------------
module spi_ram_ctrl_p #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // One extra bit so MEM_DEPTH == 2**DATA_W is representable.
  localparam logic [DATA_W:0] DEPTH_EXT = (DATA_W + 1)'(MEM_DEPTH);

`ifdef SPI_RAM_AUTOINC_EN
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] ONE_ADDR  = ADDR_SIZE'(1);

  // Pointer advance wraps at the real depth, not at 2**ADDR_SIZE.
  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] ptr);
    logic [ADDR_SIZE-1:0] nxt;
    if (ptr == LAST_ADDR) begin
      nxt = {ADDR_SIZE{1'b0}};
    end else begin
      nxt = ptr + ONE_ADDR;
    end
    return nxt;
  endfunction
`endif

  logic [DATA_W-1:0]    mem [MEM_DEPTH];

  logic [1:0]           cmd;
  logic [DATA_W-1:0]    payload;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic                 addr_ok;
  logic                 mem_we;

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic                 wr_vld_q, wr_vld_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;

  assign cmd          = din[DATA_W+1:DATA_W];
  assign payload      = din[DATA_W-1:0];
  assign payload_addr = payload[ADDR_SIZE-1:0];
  // Full payload is compared, so stray bits above ADDR_SIZE are rejected too.
  assign addr_ok      = ({1'b0, payload} < DEPTH_EXT);

  // Frame decode: next pointer/flag state, write enable and output pulses.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_vld_d   = wr_vld_q;
    rd_vld_d   = rd_vld_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: begin
          if (addr_ok) begin
            wr_ptr_d = payload_addr;
            wr_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_WR_DATA: begin
          if (wr_vld_q) begin
            mem_we = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            wr_ptr_d = ptr_inc(wr_ptr_q);
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RD_ADDR: begin
          if (addr_ok) begin
            rd_ptr_d = payload_addr;
            rd_vld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_RD_DATA: begin
          if (rd_vld_q) begin
            // A write accepted on the previous edge is already in mem here.
            dout_d     = mem[rd_ptr_q];
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
            rd_ptr_d = ptr_inc(rd_ptr_q);
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end else begin
      tx_valid_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  // Control/output registers; async reset clears pointers, flags and pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {ADDR_SIZE{1'b0}};
      rd_ptr_q   <= {ADDR_SIZE{1'b0}};
      wr_vld_q   <= 1'b0;
      rd_vld_q   <= 1'b0;
      dout_q     <= {DATA_W{1'b0}};
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_vld_q   <= wr_vld_d;
      rd_vld_q   <= rd_vld_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Memory write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= payload;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl_p.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_ctrl_p
//
// Main DUT (256 words) is checked every cycle against a frame-level model
// built from the command rules; directed sequences add literal expectations.
// A second DUT (200 words) covers the range check and depth-modulo wrap.
// -----------------------------------------------------------------------------
module tb_spi_ram_ctrl_p;

  localparam int M_DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [9:0] din = 10'h000;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  logic       rx2 = 1'b0;
  logic [9:0] din2 = 10'h000;
  logic [7:0] dout2;
  logic       tx2;
  logic       err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl_p #(.DATA_W(8), .MEM_DEPTH(256), .ADDR_SIZE(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
    .dout(dout), .tx_valid(tx_valid), .err(err)
  );

  spi_ram_ctrl_p #(.DATA_W(8), .MEM_DEPTH(200), .ADDR_SIZE(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx2), .din(din2),
    .dout(dout2), .tx_valid(tx2), .err(err2)
  );

  // ---------------- behavioural model of the main DUT ----------------
  logic [7:0] m_mem [M_DEPTH];
  bit         m_known [M_DEPTH];
  int         m_wp, m_rp;
  bit         m_wv, m_rv;
  logic [7:0] m_dout;
  bit         m_dknown;
  bit         m_tx, m_err;

  task automatic model_reset();
    m_wp = 0; m_rp = 0; m_wv = 1'b0; m_rv = 1'b0;
    m_dout = 8'h00; m_dknown = 1'b1; m_tx = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [9:0] f);
    int c;
    int p;
    c = int'(f[9:8]);
    p = int'(f[7:0]);
    m_tx = 1'b0;
    m_err = 1'b0;
    if (v) begin
      case (c)
        0: if (p < M_DEPTH) begin m_wp = p; m_wv = 1'b1; end else m_err = 1'b1;
        1: if (m_wv) begin
             m_mem[m_wp] = f[7:0];
             m_known[m_wp] = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
             m_wp = (m_wp + 1) % M_DEPTH;
`endif
           end else m_err = 1'b1;
        2: if (p < M_DEPTH) begin m_rp = p; m_rv = 1'b1; end else m_err = 1'b1;
        default: if (m_rv) begin
             m_dout = m_mem[m_rp];
             m_dknown = m_known[m_rp];
             m_tx = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
             m_rp = (m_rp + 1) % M_DEPTH;
`endif
           end else m_err = 1'b1;
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < M_DEPTH; i++) m_known[i] = 1'b0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(rx_valid, din);
    end
  end

  // Per-cycle comparison of the main DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        total++;
        if (tx_valid !== m_tx || err !== m_err || (m_dknown && dout !== m_dout)) begin
          bad++;
          $display("FAIL model_cmp t=%0t tx_valid=%b exp=%b err=%b exp=%b dout=%h exp=%h",
                   $time, tx_valid, m_tx, err, m_err, dout, m_dout);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; rx_valid = 1'b0; rx2 = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame(input logic [1:0] c, input logic [7:0] p);
    rx_valid = 1'b1; din = {c, p};
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame2(input logic [1:0] c, input logic [7:0] p);
    rx2 = 1'b1; din2 = {c, p};
    @(posedge clk);
    @(negedge clk);
    rx2 = 1'b0;
  endtask

  logic [7:0] e0, e1, e2;

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk("reset_dout", dout, 8'h00);
    chk("reset_tx", tx_valid, 1'b0);
    chk("reset_err", err, 1'b0);

    // read before any address
    frame(2'b11, 8'h00);
    chk("rd_noaddr_err", err, 1'b1);
    chk("rd_noaddr_tx", tx_valid, 1'b0);
    chk("rd_noaddr_dout", dout, 8'h00);

    // preload address 0, reset, then unaddressed write must be rejected
    frame(2'b00, 8'h00);
    frame(2'b01, 8'h77);
    do_reset();
    frame(2'b01, 8'h3C);
    chk("wr_noaddr_err", err, 1'b1);
    frame(2'b10, 8'h00);
    frame(2'b11, 8'h00);
    chk("wr_noaddr_mem", dout, 8'h77);

    // basic write / read
    frame(2'b00, 8'h05);
    frame(2'b01, 8'hA5);
    frame(2'b10, 8'h05);
    frame(2'b11, 8'h00);
    chk("basic_tx", tx_valid, 1'b1);
    chk("basic_dout", dout, 8'hA5);
    chk("basic_err", err, 1'b0);
    @(negedge clk);
    chk("tx_one_cycle", tx_valid, 1'b0);
    chk("dout_hold", dout, 8'hA5);

    // write immediately followed by read of the same address, then 11,11
    frame(2'b10, 8'h10);
    frame(2'b00, 8'h10);
    frame(2'b01, 8'h11);
    frame(2'b11, 8'h00);
    chk("wr_then_rd", dout, 8'h11);
    frame(2'b11, 8'h00);
    chk("b2b_tx1", tx_valid, 1'b1);
    frame(2'b11, 8'h00);
    chk("b2b_tx2", tx_valid, 1'b1);

    // burst at the top of memory
`ifdef SPI_RAM_AUTOINC_EN
    e0 = 8'h01; e1 = 8'h02; e2 = 8'h03;
`else
    e0 = 8'h03; e1 = 8'h03; e2 = 8'h03;
`endif
    frame(2'b00, 8'hFE);
    frame(2'b01, 8'h01);
    frame(2'b01, 8'h02);
    frame(2'b01, 8'h03);
    frame(2'b10, 8'hFE);
    frame(2'b11, 8'h00);
    chk("burst_rd0", dout, e0);
    frame(2'b11, 8'h00);
    chk("burst_rd1", dout, e1);
    frame(2'b11, 8'h00);
    chk("burst_rd2", dout, e2);

    // reset in the cycle carrying a tx_valid pulse
    frame(2'b10, 8'h05);
    frame(2'b11, 8'h00);
    chk("pre_rst_tx", tx_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx_valid, 1'b0);
    chk("rst_mid_dout", dout, 8'h00);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    frame(2'b11, 8'h00);
    chk("post_rst_rd_err", err, 1'b1);
    chk("post_rst_rd_tx", tx_valid, 1'b0);

    // randomized traffic, checked by the per-cycle compare
    frame(2'b00, 8'($urandom_range(0, 255)));
    frame(2'b10, 8'($urandom_range(0, 255)));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      else frame(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    // 200-word instance: range check and wrap
    do_reset();
    frame2(2'b00, 8'hC8);
    chk("range_c8_err", err2, 1'b1);
    frame2(2'b01, 8'h55);
    chk("range_wvld_kept0", err2, 1'b1);
    frame2(2'b00, 8'hC7);
    chk("range_c7_ok", err2, 1'b0);
    frame2(2'b01, 8'h9A);
    chk("range_wr_ok", err2, 1'b0);
    frame2(2'b10, 8'hC7);
    frame2(2'b11, 8'h00);
    chk("range_rd_tx", tx2, 1'b1);
    chk("range_rd_dout", dout2, 8'h9A);
    frame2(2'b10, 8'hFF);
    chk("range_ff_err", err2, 1'b1);
    frame2(2'b00, 8'hC7);
    frame2(2'b01, 8'hAA);
    frame2(2'b01, 8'hBB);
`ifdef SPI_RAM_AUTOINC_EN
    frame2(2'b10, 8'h00);
`else
    frame2(2'b10, 8'hC7);
`endif
    frame2(2'b11, 8'h00);
    chk("wrap_dout", dout2, 8'hBB);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl_p.md
Name: spi_ram_ctrl_p

Overview:
- Parametrised next-generation single-port RAM slave behind the SPI slave shift logic inside the SPI wrapper.
- Receives framed words (2-bit command + payload) on rx_valid.
- Holds independent write and read address pointers, performs writes, and returns read data with a tx_valid pulse for the SPI slave to shift out.
- Adds over the previous RAM: configurable width/depth, pointer-valid tracking, range and protocol error flagging, and optional burst auto-increment.

Parameters:
- DATA_W, 8: payload / memory word width; din width is DATA_W+2.
- MEM_DEPTH, 256: number of memory words; any value 2..2**DATA_W.
- ADDR_SIZE, 8: address pointer width; must satisfy 2**ADDR_SIZE >= MEM_DEPTH and ADDR_SIZE <= DATA_W.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  din carries a valid frame this cycle.
- din  input  DATA_W+2  [DATA_W+1:DATA_W]=cmd, [DATA_W-1:0]=payload.
- dout  output  DATA_W  read data, registered.
- tx_valid  output  1  one-cycle pulse, dout valid.
- err  output  1  one-cycle pulse, frame rejected.

Behaviour:
- Reset (async assert, sync-released by the system):
  - dout=0, tx_valid=0, err=0.
  - wr_ptr=0, rd_ptr=0, wr_vld=0, rd_vld=0.
  - Memory contents are not reset.
- One frame per cycle. Frames are processed only when rx_valid=1; rx_valid=0 is a no-op, and tx_valid and err drop to 0 on that cycle.
- Address range check: a payload address is out of range when payload[DATA_W-1:0] >= MEM_DEPTH. This includes non-zero bits above ADDR_SIZE.
- cmd 00 (write address):
  - In range: wr_ptr<=payload[ADDR_SIZE-1:0], wr_vld<=1.
  - Out of range: err=1, pointer and wr_vld unchanged.
- cmd 01 (write data):
  - wr_vld=1: mem[wr_ptr]<=payload, committed at this edge.
  - wr_vld=0: err=1, no write.
- cmd 10 (read address): same as cmd 00, acting on rd_ptr/rd_vld.
- cmd 11 (read data; payload ignored):
  - rd_vld=1: dout<=mem[rd_ptr] and tx_valid=1 on the next edge. Latency is 1 cycle from the accepting edge.
  - rd_vld=0: err=1, dout unchanged, tx_valid=0.
- tx_valid and err are each exactly one cycle per event. dout holds its value until the next successful read.
- Back-to-back frames are supported with no bubble, including 11,11.
- Write-then-read of the same address in consecutive cycles returns the new data, because the write commits before the read edge.
- Pointers are independent. A write never alters rd_ptr, and vice versa.
- Reset mid-operation: a pending tx_valid is cancelled immediately (async), and both pointer-valid flags clear. Subsequent cmd 01 or cmd 11 without a new address raises err.

Optional Feature:
- Macro: SPI_RAM_AUTOINC_EN.
- Defined: after each successful cmd 01, wr_ptr increments; after each successful cmd 11, rd_ptr increments. Both wrap from MEM_DEPTH-1 to 0 (modulo MEM_DEPTH, not 2**ADDR_SIZE). This enables burst transfers with a single address frame.
- Undefined: pointers change only on cmd 00 or cmd 10, and repeated data frames hit the same address.

Test Plan (DATA_W=8, MEM_DEPTH=256 unless stated):
- Reset then frames 0x0_05 (cmd 00), 0x1_A5 (cmd 01), 0x2_05 (cmd 10), 0x3_00 (cmd 11) -> tx_valid pulse one cycle after the cmd-11 edge, dout=0xA5, err stays 0.
- After reset, cmd 11 issued first -> err one-cycle pulse, tx_valid=0, dout=0. After reset, cmd 01 payload 0x3C with no write address -> err pulse and mem unchanged; a later read of address 0 returns its prior content.
- MEM_DEPTH=200, cmd 00 payload 0xC8 -> err pulse, wr_vld stays 0. cmd 00 payload 0xC7 -> accepted, err=0.
- Write 0x11 to address 0x10, then on the very next cycle cmd 10 payload 0x10 followed by cmd 11 -> dout=0x11. Back-to-back cmd 11,11 -> two tx_valid pulses on consecutive cycles.
- SPI_RAM_AUTOINC_EN defined, MEM_DEPTH=256: cmd 00 payload 0xFE, then data 0x01, 0x02, 0x03 -> mem[0xFE]=0x01, mem[0xFF]=0x02, mem[0x00]=0x03. cmd 10 payload 0xFE, then three cmd 11 -> dout sequence 0x01, 0x02, 0x03.
- Assert rst_n low in the cycle after a cmd 11 -> tx_valid=0 and dout=0 immediately. After release, cmd 11 -> err pulse.
